// File: rtl/parser_pkg.sv
// parser_pkg: types and constants shared by the OBU parsing chain.
package parser_pkg;
   localparam int PARSER_DATA_WIDTH = 64;
   typedef enum logic [3:0] {
      SEQUENCE_HEADER        = 4'd1,
      TEMPORAL_DELIMITER     = 4'd2,
      FRAME_HEADER           = 4'd3,
      TILE_GROUP             = 4'd4,
      METADATA               = 4'd5,
      FRAME                  = 4'd6,
      REDUNDANT_FRAME_HEADER = 4'd7,
      TILE_LIST              = 4'd8,
      PADDING                = 4'd15
   } obu_type_e;
   typedef struct packed {
      logic [3:0]  obu_type;
      logic        extension_flag;
      logic        has_size_field;
      logic [2:0]  temporal_id;
      logic [1:0]  spatial_id;
      logic [31:0] obu_size;
   } obu_header_t;
endpackage

// File: rtl/obu_header_parser_if.sv
// obu_header_parser_if: bit-window handshake between the upstream aligner and the OBU header parser.
interface obu_header_parser_if import parser_pkg::*; #(
   parameter int PARSER_DATA_WIDTH = parser_pkg::PARSER_DATA_WIDTH
);
   logic [PARSER_DATA_WIDTH-1:0]         data_in;
   logic                                 data_valid;
   logic                                 start;
   logic                                 busy;
   logic                                 done;
   logic                                 error;
   obu_header_t                          obu_header;
   logic                                 pad;
   logic [$clog2(PARSER_DATA_WIDTH)-1:0] pad_len;
   logic                                 pop;
   modport master (output data_in, data_valid, start,
                   input busy, done, error, obu_header, pad, pad_len, pop);
   modport slave  (input data_in, data_valid, start,
                   output busy, done, error, obu_header, pad, pad_len, pop);
endinterface

// File: rtl/leb128_decoder.sv
// leb128_decoder: byte-serial leb128 accumulator into 32 bits; flags payload bits beyond bit 31
// and a continuation bit on the last permitted byte.
module leb128_decoder #(
   parameter int MAX_BYTES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        last,
   output logic        overflow,
   output logic [31:0] value
);
   localparam int CW = $clog2(MAX_BYTES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   value_q, value_d;
   logic          hi_bits;
   always_comb begin
      // byte 4 lands at bits 28..34, later bytes entirely at 35 and up
      hi_bits  = cnt_q > CW'(4) ? |byte_in[6:0] : cnt_q == CW'(4) && |byte_in[6:4];
      overflow = byte_valid && (hi_bits || (cnt_q == CW'(MAX_BYTES - 1) && byte_in[7]));
      last     = byte_valid && (!byte_in[7] || overflow);
      value_d  = clear ? '0 : byte_valid ? value_q | (32'(byte_in[6:0]) << (7 * cnt_q)) : value_q;
      cnt_d    = clear ? '0 : byte_valid ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q   <= '0;
         value_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         value_q <= value_d;
      end
   assign value = value_q;
endmodule

// File: rtl/obu_header_parser.sv
// obu_header_parser: byte-serial AV1 OBU header parser; extracts header, extension and leb128 size,
// then reports how much of the current window it consumed.
module obu_header_parser import parser_pkg::*; #(
   parameter int PARSER_DATA_WIDTH = parser_pkg::PARSER_DATA_WIDTH,
   parameter int MAX_LEB128_BYTES  = 8
) (
   input logic                clk,
   input logic                rst_n,
   obu_header_parser_if.slave bus
);
   localparam int NB = PARSER_DATA_WIDTH / 8;
   localparam int PW = $clog2(PARSER_DATA_WIDTH);
   localparam int BW = NB > 1 ? $clog2(NB) : 1;
   typedef enum logic [2:0] {IDLE, HDR, EXT, SIZE, FIN} state_e;
   state_e        state_q, state_d;
   logic [BW-1:0] ptr_q, ptr_d;
   obu_header_t   hdr_q, hdr_d;
   logic          err_q, err_d, busy_q, busy_d, done_q, done_d, error_q, error_d, pad_q, pad_d;
   logic [PW-1:0] pad_len_q, pad_len_d;
   logic [7:0]    cur;
   logic          consume, last_byte, leb_last, leb_ovf;
   logic [31:0]   leb_value;
   assign cur       = 8'(bus.data_in >> (PARSER_DATA_WIDTH - 8 - 8 * ptr_q));
   assign consume   = bus.data_valid && (state_q == HDR || state_q == EXT || state_q == SIZE);
   assign last_byte = ptr_q == BW'(NB - 1);
   leb128_decoder #(.MAX_BYTES(MAX_LEB128_BYTES)) u_leb (
      .clk(clk),
      .rst_n(rst_n),
      .clear(state_q == IDLE && bus.start),
      .byte_valid(consume && state_q == SIZE),
      .byte_in(cur),
      .last(leb_last),
      .overflow(leb_ovf),
      .value(leb_value)
   );
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hdr_d   = hdr_q;
      err_d   = err_q;
      if (state_q == IDLE && bus.start) begin
         state_d = HDR;
         ptr_d   = '0;
         hdr_d   = '0;
         err_d   = 1'b0;
      end else if (consume) begin
         ptr_d = last_byte ? '0 : ptr_q + 1'b1;
         case (state_q)
            HDR: begin
               hdr_d.obu_type       = cur[6:3];
               hdr_d.extension_flag = cur[2];
               hdr_d.has_size_field = cur[1];
               err_d                = cur[7];
               state_d              = cur[7] ? FIN : cur[2] ? EXT : cur[1] ? SIZE : FIN;
            end
            EXT: begin
               hdr_d.temporal_id = cur[7:5];
               hdr_d.spatial_id  = cur[4:3];
               state_d           = hdr_q.has_size_field ? SIZE : FIN;
            end
            default: begin
               err_d   = leb_ovf;
               state_d = leb_last ? FIN : SIZE;
            end
         endcase
      end else if (state_q == FIN) begin
         state_d = IDLE;
      end
      busy_d    = state_d != IDLE;
      done_d    = state_d == FIN;
      error_d   = done_d && err_d;
      pad_d     = done_d && ptr_d != '0;
      pad_len_d = pad_d ? PW'({ptr_d, 3'b000}) : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         hdr_q     <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         pad_q     <= 1'b0;
         pad_len_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hdr_q     <= hdr_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         pad_q     <= pad_d;
         pad_len_q <= pad_len_d;
      end
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.error   = error_q;
   assign bus.pad     = pad_q;
   assign bus.pad_len = pad_len_q;
   assign bus.pop     = consume && last_byte;
   // the size field lives in the decoder so it is final in the same cycle as done
   always_comb begin
      bus.obu_header          = hdr_q;
      bus.obu_header.obu_size = leb_value;
   end
endmodule
